board_setup_ctrl: RTL and testbench



---
 rtl/chess_pkg.sv | 64 ++++++
 rtl/board_lfsr.sv | 23 ++
 rtl/board_setup_ctrl.sv | 143 ++++++++++++++
 tb/tb_board_setup_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared dark-chess encodings: piece codes, colors, cover state, address split
// and the canonical index-to-piece mapping used at setup.
package chess_pkg;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned PIECE_W    = 5;
  localparam int unsigned ENTRY_W    = 4;
  localparam int unsigned NUM_PIECES = 32;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned DRAW_W     = 5;

  localparam logic [2:0] PIECE_EMPTY   = 3'b000;
  localparam logic [2:0] PIECE_SOLDIER = 3'b001;
  localparam logic [2:0] PIECE_CANNON  = 3'b010;
  localparam logic [2:0] PIECE_KNIGHT  = 3'b011;
  localparam logic [2:0] PIECE_ROOK    = 3'b100;
  localparam logic [2:0] PIECE_BISHOP  = 3'b101;
  localparam logic [2:0] PIECE_QUEEN   = 3'b110;
  localparam logic [2:0] PIECE_KING    = 3'b111;

  localparam logic COLOR_RED       = 1'b0;
  localparam logic COLOR_BLACK     = 1'b1;
  localparam logic STATE_COVERED   = 1'b0;
  localparam logic STATE_UNCOVERED = 1'b1;

  // Board address is {row[1:0], col[2:0]}
  localparam int unsigned ROW_MSB = 4;
  localparam int unsigned ROW_LSB = 3;
  localparam int unsigned COL_MSB = 2;
  localparam int unsigned COL_LSB = 0;

  typedef struct packed {
    logic       color;
    logic [2:0] kind;
    logic       state;
  } piece_t;

  function automatic logic [2:0] canonical_type(input logic [3:0] idx);
    logic [2:0] t;
    t = PIECE_SOLDIER;
    if (idx == 4'd0)       t = PIECE_KING;
    else if (idx <= 4'd2)  t = PIECE_QUEEN;
    else if (idx <= 4'd4)  t = PIECE_BISHOP;
    else if (idx <= 4'd6)  t = PIECE_ROOK;
    else if (idx <= 4'd8)  t = PIECE_KNIGHT;
    else if (idx <= 4'd10) t = PIECE_CANNON;
    return t;
  endfunction

  function automatic logic [ENTRY_W-1:0] canonical_entry(input logic [4:0] idx);
    return {idx[4], canonical_type(idx[3:0])};
  endfunction

  // Smallest all-ones mask covering v, i.e. (next power of two >= v+1) - 1
  function automatic logic [4:0] span_mask(input logic [4:0] v);
    logic [4:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/board_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), low bits exposed as a draw.
module board_lfsr
  import chess_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DRAW_W-1:0] draw
);

  logic [LFSR_W-1:0] value;
  logic              feedback;

  assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];
  assign draw     = value[DRAW_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= SEED;
    else     value <= {feedback, value[LFSR_W-1:1]};
  end

endmodule

// File: rtl/board_setup_ctrl.sv
// Owns the board write port: shuffles and writes 32 covered pieces after reset or
// new_game, then passes game-logic writes straight through.
module board_setup_ctrl
  import chess_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned MAX_REJECT = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       new_game,
  input  logic [4:0] logic_addr,
  input  logic [4:0] logic_piece,
  input  logic       logic_we,
  output logic [4:0] board_wr_addr,
  output logic [4:0] board_wr_piece,
  output logic       board_wr_en,
  output logic       logic_hold,
  output logic       setup_done
);

  localparam int unsigned REJ_W = (MAX_REJECT > 0) ? $clog2(MAX_REJECT + 1) : 1;
  localparam logic [REJ_W-1:0] REJ_MAX = REJ_W'(MAX_REJECT);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_SHUFFLE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_IDLE    = 2'd3;

  logic [1:0]         state, state_nx;
  logic [4:0]         idx, idx_nx;
  logic [4:0]         k, k_nx;
  logic [REJ_W-1:0]   rej, rej_nx;
  logic [ENTRY_W-1:0] list [NUM_PIECES];

  logic [DRAW_W-1:0] draw;
  logic [4:0]        j_raw;
  logic [4:0]        j_sel;
  logic              accept;
  logic              forced;
  logic              swap_en;

  board_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (CLK),
    .rst  (RESET),
    .draw (draw)
  );

  // Draw evaluation: accept in-range j, otherwise count rejects until the fallback j = i
  always_comb begin
    j_raw   = draw & span_mask(idx);
    accept  = (j_raw <= idx);
    forced  = !accept && (rej >= REJ_MAX);
    j_sel   = forced ? idx : j_raw;
    swap_en = (state == ST_SHUFFLE) && (accept || forced);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_LOAD;
      idx   <= 5'd31;
      k     <= 5'd0;
      rej   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      k     <= k_nx;
      rej   <= rej_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    k_nx     = k;
    rej_nx   = rej;
    case (state)
      ST_LOAD: begin
        idx_nx   = 5'd31;
        rej_nx   = '0;
        state_nx = ST_SHUFFLE;
      end
      ST_SHUFFLE: begin
        if (accept || forced) begin
          idx_nx = idx - 5'd1;
          rej_nx = '0;
          if (idx == 5'd1) begin
            k_nx     = 5'd0;
            state_nx = ST_WRITE;
          end
        end else begin
          rej_nx = rej + REJ_W'(1);
        end
      end
      ST_WRITE: begin
        k_nx = k + 5'd1;
        if (k == 5'd31) state_nx = ST_IDLE;
      end
      default: ;
    endcase
    // A new game restarts setup from any state, abandoning partial work
    if (new_game) begin
      state_nx = ST_LOAD;
      idx_nx   = 5'd31;
      k_nx     = 5'd0;
      rej_nx   = '0;
    end
  end

  // Piece list: canonical fill in LOAD, one registered swap per accepted draw
  always_ff @(posedge CLK) begin
    if (state == ST_LOAD) begin
      for (int n = 0; n < NUM_PIECES; n++) list[n] <= canonical_entry(5'(n));
    end else if (swap_en) begin
      list[idx]   <= list[j_sel];
      list[j_sel] <= list[idx];
    end
  end

  always_comb begin
    board_wr_addr  = 5'd0;
    board_wr_piece = 5'd0;
    board_wr_en    = 1'b0;
    logic_hold     = 1'b1;
    setup_done     = 1'b0;
    case (state)
      ST_WRITE: begin
        board_wr_en    = 1'b1;
        board_wr_addr  = k;
        board_wr_piece = {list[k], STATE_COVERED};
      end
      ST_IDLE: begin
        board_wr_en    = logic_we;
        board_wr_addr  = logic_addr;
        board_wr_piece = logic_piece;
        logic_hold     = 1'b0;
        setup_done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_setup_ctrl.sv
// Randomized scoreboard bench for board_setup_ctrl against a whole-shuffle reference model.
module tb_board_setup_ctrl;

  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          MAX_REJECT = 7;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       new_game;
  logic [4:0] logic_addr;
  logic [4:0] logic_piece;
  logic       logic_we;
  logic [4:0] board_wr_addr;
  logic [4:0] board_wr_piece;
  logic       board_wr_en;
  logic       logic_hold;
  logic       setup_done;

  board_setup_ctrl #(.SEED(SEED), .MAX_REJECT(MAX_REJECT)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .new_game       (new_game),
    .logic_addr     (logic_addr),
    .logic_piece    (logic_piece),
    .logic_we       (logic_we),
    .board_wr_addr  (board_wr_addr),
    .board_wr_piece (board_wr_piece),
    .board_wr_en    (board_wr_en),
    .logic_hold     (logic_hold),
    .setup_done     (setup_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] addr;
    logic [4:0] piece;
    logic       setup;
  } wr_t;

  wr_t wr_q[$];
  bit  st_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;
  int finish_req = 0;
  int snap_req = 0;
  int snap_seen = 0;
  logic       snap_en, snap_hold, snap_done;
  logic [4:0] snap_addr, snap_piece;

  logic [3:0] plan_list [32];
  int         plan_shuffle;
  logic [15:0] model_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int unsigned x, fb;
    x  = v;
    fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (fb << 15));
  endfunction

  function automatic int type_count(input int t);
    case (t)
      7: return 1;
      1: return 5;
      0: return 0;
      default: return 2;
    endcase
  endfunction

  // Whole setup in one go: canonical list, then Fisher-Yates with one draw per cycle
  task automatic plan_setup(input logic [15:0] v_load);
    logic [15:0] v;
    logic [3:0]  tmp;
    int n, i, rej, span, j;
    n = 0;
    for (int c = 0; c < 2; c++)
      for (int t = 7; t >= 1; t--)
        for (int q = 0; q < type_count(t); q++) begin
          plan_list[n] = 4'((c << 3) | t);
          n++;
        end
    v = lfsr_step(v_load);
    i = 31;
    rej = 0;
    plan_shuffle = 0;
    while (i >= 1) begin
      span = 1;
      while (span < i + 1) span = span * 2;
      j = int'(v[4:0]) % span;
      plan_shuffle++;
      if (j <= i) begin
        tmp = plan_list[i];
        plan_list[i] = plan_list[j];
        plan_list[j] = tmp;
        i--;
        rej = 0;
      end else if (rej < MAX_REJECT) begin
        rej++;
      end else begin
        i--;
        rej = 0;
      end
      v = lfsr_step(v);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a status cycle
  initial begin : monitor
    int  hist [16];
    wr_t e;
    bit  d;
    foreach (hist[n]) hist[n] = 0;
    forever begin
      @(negedge CLK);
      if (snap_seen != snap_req) begin
        snap_seen = snap_req;
        check("reset_wr_en", int'(snap_en), 0);
        check("reset_wr_addr", int'(snap_addr), 0);
        check("reset_wr_piece", int'(snap_piece), 0);
        check("reset_logic_hold", int'(snap_hold), 1);
        check("reset_setup_done", int'(snap_done), 0);
      end
      if (finish_req != 0) begin
        check("run_complete", finish_req, 1);
        check("wr_queue_drained", wr_q.size(), 0);
        check("status_queue_drained", st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (mon_on) begin
        if (st_q.size() == 0) begin
          check("status_expected", 0, 1);
        end else begin
          d = st_q.pop_front();
          check("setup_done", int'(setup_done), int'(d));
          check("logic_hold", int'(logic_hold), int'(!d));
        end
        if (board_wr_en) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write_addr", int'(board_wr_addr), -1);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", int'(board_wr_addr), int'(e.addr));
            check("wr_piece", int'(board_wr_piece), int'(e.piece));
            if (e.setup) begin
              if (e.addr == 5'd0) foreach (hist[n]) hist[n] = 0;
              hist[board_wr_piece[4:1]]++;
              if (e.addr == 5'd31)
                for (int c = 0; c < 2; c++)
                  for (int t = 0; t < 8; t++)
                    check("piece_count", hist[c * 8 + t], type_count(t));
            end
          end
        end
      end
    end
  end

  // Stimulus: drives one cycle at a time and pushes what that cycle must produce
  initial begin : driver
    int  n_setups, pc, idle_cnt, rst_hold;
    bit  in_setup, stop;
    n_setups = 0; pc = 0; idle_cnt = 0; rst_hold = 0;
    in_setup = 1'b0; stop = 1'b0;
    RESET = 1'b1;
    new_game = 1'b0;
    logic_we = 1'b0;
    logic_addr = 5'd0;
    logic_piece = 5'd0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_lfsr = SEED;
    plan_setup(model_lfsr);
    n_setups = 1; pc = 0; in_setup = 1'b1;
    mon_on = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (stop) break;
      new_game    = 1'b0;
      logic_we    = 1'($urandom);
      logic_addr  = 5'($urandom);
      logic_piece = 5'($urandom);
      if (rst_hold > 0) begin
        st_q.push_back(1'b0);
      end else if (in_setup) begin
        if (n_setups == 1) begin
          logic_we   = 1'b1;
          logic_addr = 5'd7;
        end
        if (n_setups == 2 && pc == 1 + plan_shuffle + 10) new_game = 1'b1;
        if (n_setups == 4 && pc == 1 + plan_shuffle / 2) begin
          RESET = 1'b1;
          #1;
          snap_en = board_wr_en; snap_addr = board_wr_addr; snap_piece = board_wr_piece;
          snap_hold = logic_hold; snap_done = setup_done;
          snap_req++;
          rst_hold = 3;
        end
        st_q.push_back(1'b0);
        if (!RESET && pc >= 1 + plan_shuffle)
          wr_q.push_back('{addr: 5'(pc - 1 - plan_shuffle),
                           piece: {plan_list[pc - 1 - plan_shuffle], 1'b0}, setup: 1'b1});
      end else begin
        if (idle_cnt == 0 && n_setups == 1) begin
          logic_we    = 1'b1;
          logic_addr  = 5'b01_011;
          logic_piece = 5'b1_100_1;
        end
        if (idle_cnt == 20 && n_setups != 5) new_game = 1'b1;
        st_q.push_back(1'b1);
        if (logic_we) wr_q.push_back('{addr: logic_addr, piece: logic_piece, setup: 1'b0});
      end

      @(posedge CLK);
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin
          RESET = 1'b0;
          model_lfsr = SEED;
          plan_setup(model_lfsr);
          n_setups++; pc = 0; in_setup = 1'b1;
        end
      end else begin
        model_lfsr = lfsr_step(model_lfsr);
        if (new_game) begin
          plan_setup(model_lfsr);
          n_setups++; pc = 0; in_setup = 1'b1;
        end else if (in_setup) begin
          pc++;
          if (pc == 1 + plan_shuffle + 32) begin
            in_setup = 1'b0;
            idle_cnt = 0;
          end
        end else begin
          idle_cnt++;
          if (n_setups == 5 && idle_cnt > 25) stop = 1'b1;
        end
      end
    end
    new_game = 1'b0;
    logic_we = 1'b0;
    finish_req = stop ? 1 : 2;
  end

endmodule
